// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10
  } uart_arb_state_t;

  localparam int UART_CLK_DIVIDE       = 234;
  localparam int UART_ARB_WDOG_DEFAULT = 2 * 10 * UART_CLK_DIVIDE;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request searching upward
// from last_i+1, wrapping around.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_i,
  output logic                     any_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0] cand;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(last_i) + k) % N_REQ);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte producers.
// Optional completion watchdog enabled by defining UART_ARB_WDOG_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WDOG_CYCLES = UART_ARB_WDOG_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [8*N_REQ-1:0]       req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [N_REQ-1:0]         req_done_o,
  output logic                     tx_start_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_flag_i,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int IDW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || WDOG_CYCLES < 2 || WDOG_CYCLES > 65537) begin : g_cfg_check
    $error("uart_tx_arb: unsupported N_REQ or WDOG_CYCLES");
  end

  uart_arb_state_t  state_q, state_d;
  logic [IDW-1:0]   last_q, grant_q;
  logic [7:0]       tx_data_q;
  logic             tx_start_q;
  logic [N_REQ-1:0] ready_q, done_q;
  logic             pick_any;
  logic [IDW-1:0]   pick_idx;
  logic             launch, complete, expire;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  assign launch   = (state_q == IDLE) && pick_any;
  assign complete = (state_q == WAIT) && tx_flag_i;

`ifdef UART_ARB_WDOG_EN
  // Expiry is flagged one count early so ERR lands WDOG_CYCLES after LAUNCH.
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 2);

  logic [15:0] wdog_q, wdog_d;
  logic        err_q;

  assign expire = (state_q == WAIT) && !tx_flag_i && (wdog_q == WDOG_LAST);

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == LAUNCH)    wdog_d = '0;
    else if (state_q == WAIT) wdog_d = wdog_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= expire;
    end
  end

  assign err_o = err_q;
`else
  assign expire = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Completion takes priority over watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (tx_flag_i || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
  end

  // START, READY and DONE are registered pulses; TX_DATA holds between launches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_start_q <= 1'b0;
      ready_q    <= '0;
      done_q     <= '0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      last_q     <= IDW'(N_REQ - 1);
    end else begin
      tx_start_q <= launch;
      ready_q    <= launch ? onehot(pick_idx) : '0;
      done_q     <= complete ? onehot(grant_q) : '0;
      if (launch) begin
        tx_data_q <= req_data_i[{pick_idx, 3'b000} +: 8];
        grant_q   <= pick_idx;
      end
      if (state_q == LAUNCH) last_q <= grant_q;
    end
  end

  assign tx_start_o  = tx_start_q;
  assign req_ready_o = ready_q;
  assign req_done_o  = done_q;
  assign tx_data_o   = tx_data_q;
  assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: transaction-level reference model,
// directed scenarios and randomized traffic with an emulated uart_tx.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int WD = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic           tx_flag;
  logic [N-1:0]   req_ready, req_done;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [1:0]     grant_id;
  logic           busy, err;

  always #5 clk = ~clk;

  uart_tx_arb #(.N_REQ(N), .WDOG_CYCLES(WD)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .req_done_o  (req_done),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .tx_flag_i   (tx_flag),
    .grant_id_o  (grant_id),
    .busy_o      (busy),
    .err_o       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one byte outstanding, owner, last grant, pending pulses.
  bit         m_out, m_launch, m_err;
  int         m_owner, m_last, m_wait;
  logic [7:0] m_data;
  logic [N-1:0] m_done;

  // Stimulus controls and DUT observation logs.
  int           flag_at, fixed_delay;
  bit           flag_en, spur_en;
  logic [N-1:0] auto_mask, refill_mask, set_valid, prev_ready;
  logic [7:0]   set_byte [N];
  int           start_cyc[$], done_cyc[$], err_cyc[$], grants[$];
  logic [7:0]   start_data[$];

  function automatic int rr_ref(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_out = 0; m_launch = 0; m_err = 0; m_owner = 0; m_last = N - 1;
    m_wait = 0; m_data = '0; m_done = '0;
    prev_ready = '0; req_valid = '0; set_valid = '0; tx_flag = 1'b0;
  endtask

  task automatic clear_logs();
    start_cyc.delete(); done_cyc.delete(); err_cyc.delete();
    grants.delete(); start_data.delete();
  endtask

  task automatic step();
    logic [N-1:0] exp_ready, nxt_done;
    bit nxt_launch, nxt_err;
    int w;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (prev_ready[i]) begin
        if (refill_mask[i]) req_data[8*i +: 8] = 8'($urandom);
        else                req_valid[i] = 1'b0;
      end
      if (set_valid[i]) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = set_byte[i];
      end else if (auto_mask[i] && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = 8'($urandom);
      end else if (auto_mask[i] && req_valid[i] && $urandom_range(0, 63) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
    set_valid = '0;
    tx_flag = (flag_en && cyc == flag_at) || (spur_en && $urandom_range(0, 29) == 0);

    @(negedge clk);
    exp_ready = m_launch ? (4'(1) << m_owner) : '0;
    check_eq("ready", req_ready, exp_ready);
    check_eq("start", tx_start, m_launch);
    check_eq("done", req_done, m_done);
    check_eq("busy", busy, m_out);
    check_eq("err", err, m_err);
    check_eq("tx_data", tx_data, m_data);
    check_eq("grant_id", grant_id, m_owner);

    if (tx_start) begin
      start_cyc.push_back(cyc);
      start_data.push_back(tx_data);
      flag_at = cyc + ((fixed_delay > 0) ? fixed_delay : $urandom_range(1, 8));
    end
    for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
    if (req_done != '0) done_cyc.push_back(cyc);
    if (err) err_cyc.push_back(cyc);

    nxt_done = '0; nxt_launch = 0; nxt_err = 0;
    if (!m_out) begin
      w = rr_ref(req_valid, m_last);
      if (w >= 0) begin
        m_out = 1; nxt_launch = 1; m_owner = w; m_last = w; m_wait = 0;
        m_data = req_data[8*w +: 8];
      end
    end else if (!m_launch) begin
      m_wait++;
      if (tx_flag) begin
        nxt_done = 4'(1) << m_owner;
        m_out = 0;
      end
`ifdef UART_ARB_WDOG_EN
      else if (m_wait == WD - 1) begin
        nxt_err = 1;
        m_out = 0;
      end
`endif
    end
    m_launch = nxt_launch;
    m_done = nxt_done;
    m_err = nxt_err;
    prev_ready = exp_ready;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_eq("rst_outs", {req_ready, req_done, tx_start, tx_data, grant_id, busy, err}, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_data = '0; flag_at = -1; flag_en = 1; spur_en = 0;
    fixed_delay = 0; auto_mask = '0; refill_mask = '0;
    for (int i = 0; i < N; i++) set_byte[i] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs", {req_ready, req_done, tx_start, tx_data, grant_id, busy, err}, '0);
    rst_n = 1'b1;

    // Single requester 0, byte 0x55.
    clear_logs();
    fixed_delay = 3; set_valid[0] = 1'b1; set_byte[0] = 8'h55;
    run(10);
    check_eq("t1_starts", start_cyc.size(), 1);
    check_eq("t1_data", start_data.size() > 0 ? start_data[0] : 8'hxx, 8'h55);
    check_eq("t1_grant", grants.size() > 0 ? grants[0] : -1, 0);
    check_eq("t1_done_lat", done_cyc.size() > 0 ? done_cyc[0] - start_cyc[0] : -1, 4);

    // Reset while waiting for completion; the late flag must be ignored.
    clear_logs();
    fixed_delay = 6; set_valid[1] = 1'b1; set_byte[1] = 8'h9A;
    run(4);
    do_reset();
    run(6);
    check_eq("rst_no_done", done_cyc.size(), 0);

    // All requesters held and refilled: strict rotation from requester 0.
    clear_logs();
    fixed_delay = 0; refill_mask = '1;
    for (int i = 0; i < N; i++) begin
      set_valid[i] = 1'b1; set_byte[i] = 8'($urandom);
    end
    run(45);
    refill_mask = '0;
    run(50);
    check_eq("rot_count", grants.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("rot_%0d", i), grants.size() > i ? grants[i] : -1, i % N);

    // Wrap-around: last grant 2, requests 0 and 2 -> 0 then 2.
    clear_logs();
    set_valid[2] = 1'b1; set_byte[2] = 8'h21;
    run(15);
    set_valid[0] = 1'b1; set_byte[0] = 8'h10;
    set_valid[2] = 1'b1; set_byte[2] = 8'h22;
    run(30);
    check_eq("wrap_first", grants.size() > 1 ? grants[1] : -1, 0);
    check_eq("wrap_second", grants.size() > 2 ? grants[2] : -1, 2);

    // Back-to-back bytes from requester 1 with a clk_divide=4 frame length.
    clear_logs();
    fixed_delay = 41; set_valid[1] = 1'b1; set_byte[1] = 8'hA5;
    run(3);
    set_valid[1] = 1'b1; set_byte[1] = 8'h3C;
    run(110);
    check_eq("b2b_starts", start_cyc.size(), 2);
    check_eq("b2b_period", start_cyc.size() > 1 ? start_cyc[1] - start_cyc[0] : -1, 43);
    check_eq("b2b_data0", start_data.size() > 0 ? start_data[0] : 8'hxx, 8'hA5);
    check_eq("b2b_data1", start_data.size() > 1 ? start_data[1] : 8'hxx, 8'h3C);
    fixed_delay = 0;

`ifdef UART_ARB_WDOG_EN
    // Stalled serializer: ERR after WD cycles, then the next requester first.
    clear_logs();
    flag_en = 0; set_valid[3] = 1'b1; set_byte[3] = 8'h77;
    run(25);
    check_eq("wd_err_count", err_cyc.size(), 1);
    check_eq("wd_err_lat", (err_cyc.size() > 0 && start_cyc.size() > 0) ? err_cyc[0] - start_cyc[0] : -1, WD);
    check_eq("wd_no_done", done_cyc.size(), 0);
    flag_en = 1;
    set_valid[0] = 1'b1; set_byte[0] = 8'h01;
    set_valid[3] = 1'b1; set_byte[3] = 8'h78;
    run(30);
    check_eq("wd_next", grants.size() > 1 ? grants[1] : -1, 0);
`else
    // Without the watchdog a stalled serializer keeps the arbiter waiting.
    clear_logs();
    flag_en = 0; set_valid[3] = 1'b1; set_byte[3] = 8'h77;
    run(40);
    check_eq("nowd_err", err_cyc.size(), 0);
    check_eq("nowd_busy", busy, 1);
    do_reset();
    flag_en = 1;
`endif

    // Randomized traffic with spurious completion pulses.
    clear_logs();
    auto_mask = '1; spur_en = 1;
    run(1500);
    auto_mask = '0; spur_en = 0;
    run(40);
    check_eq("rand_traffic", start_cyc.size() > 50, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer that shares one `uart_tx` serializer among `N_REQ` byte producers. It sits between the requesters (debug console, status reporter, etc.) and the single UART TX instance. It accepts one byte at a time, launches it with a clean `START` rising edge, and waits for the serializer's `TX_FLAG` completion pulse. It then reports completion to the owning requester.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WDOG_CYCLES`, 4680: completion timeout in `CLK` cycles. Only used with `UART_ARB_WDOG_EN`. The default is 2 × 10 bits × 234.
- `CLK` in 1: system clock, the same clock as `uart_tx`.
- `RST` in 1: asynchronous, active-low reset.
- `REQ_VALID` in N_REQ: requester i has a byte pending. It must stay high, with data stable, until `REQ_READY[i]`.
- `REQ_DATA` in 8·N_REQ: byte of requester i is on bits [8i+7:8i].
- `REQ_READY` out N_REQ: one-cycle accept pulse, one-hot.
- `REQ_DONE` out N_REQ: one-cycle pulse when requester i's byte has finished its stop bit.
- `TX_START` out 1: drives `uart_tx.START`. Registered.
- `TX_DATA` out 8: drives `uart_tx.TX_DATA_IN`. Registered, and held between launches.
- `TX_FLAG` in 1: completion pulse from `uart_tx.TX_FLAG`.
- `GRANT_ID` out $clog2(N_REQ): index of the current or last owner.
- `BUSY` out 1: high in every state except IDLE.
- `ERR` out 1: one-cycle watchdog timeout pulse. Tied to 0 without the macro.

## Operation
- States are IDLE, LAUNCH and WAIT.
- **IDLE:**
  - If `REQ_VALID` is 0, stay in IDLE.
  - Otherwise pick the winner: the first set bit searching upward from `last_grant+1`, with wrap-around.
  - Capture `REQ_DATA[winner]` into `TX_DATA` and set `GRANT_ID` to the winner.
  - Go to LAUNCH.
- **LAUNCH:**
  - Lasts exactly 1 cycle.
  - `TX_START`=1 and `REQ_READY[winner]`=1.
  - Update `last_grant` to the winner and go to WAIT.
- **WAIT:**
  - `TX_START`=0.
  - On `TX_FLAG`=1: pulse `REQ_DONE[winner]` in the next cycle and go to IDLE.
- `TX_START` is high for exactly one cycle and low in the cycle before it. This guarantees `uart_tx` sees a 0→1 edge.
- At most one byte is outstanding.
- `REQ_VALID` bits that fall without a READY are dropped silently; no error is raised.
- Requests from a single requester only (one `REQ_VALID` bit set): that requester is served back-to-back, with no starvation.
- Requests from every requester (all `REQ_VALID` bits set): strict rotation 0,1,2,3,0,…

## Timing
- **Reset values:** all outputs 0 and state IDLE. `last_grant`=N_REQ-1, so requester 0 wins first.
- **Reset mid-operation:** asynchronous return to IDLE. The byte in flight is abandoned and no `REQ_DONE` is issued. `uart_tx` is reset by the same system reset.
- **Accept latency:** valid seen in IDLE in cycle t gives `REQ_READY` and `TX_START` in cycle t+1.
- **Completion latency:** `TX_FLAG` in cycle k gives `REQ_DONE` and IDLE in cycle k+1.
- **Next launch:** with a pending request, `TX_START` rises again in cycle k+2. `uart_tx` is back in IDLE by then, so no gap state is needed.
- **Byte-to-byte period:** 10·clk_divide + 3 cycles.
- **`TX_FLAG` outside WAIT:** ignored.
- **`TX_FLAG` and watchdog expiry in the same cycle:** completion wins; `ERR` stays 0.

## Configuration
- Macro: `UART_ARB_WDOG_EN`.
- **Defined:**
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `WDOG_CYCLES`-1 without `TX_FLAG`: pulse `ERR` for one cycle, pulse no `REQ_DONE`, and go to IDLE.
  - `last_grant` is kept, so the stalled requester does not retry first.
- **Undefined:** WAIT is unbounded, `ERR`=0, and no counter logic is generated.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_arb_state_t` (IDLE=2'b00, LAUNCH=2'b01, WAIT=2'b10);
  - `UART_CLK_DIVIDE`=234;
  - `UART_ARB_WDOG_DEFAULT`=4680.
- Sub-module `rr_pick`: purely combinational round-robin selector.
  - Inputs: `req[N_REQ]` and `last[$clog2(N_REQ)]`.
  - Outputs: `any`, `idx`.
- Top level: FSM, registers, watchdog.

## Test plan
- Reset, then `REQ_VALID`=4'b0001 with byte 0x55 → `REQ_READY[0]` one cycle after, `TX_START` one-cycle pulse, `TX_DATA`=0x55, `REQ_DONE[0]` one cycle after `TX_FLAG`.
- `REQ_VALID`=4'b1111, held and refilled → grant order 0,1,2,3,0 and `GRANT_ID` matches each READY.
- With `last_grant`=2, `REQ_VALID`=4'b0101 → requester 0 wins (wrap-around), then requester 2.
- Back-to-back bytes 0xA5, 0x3C from requester 1 with real `uart_tx` (clk_divide=4) → two `START` edges, serial line matches both frames, period 43 cycles.
- Assert `RST`=0 in WAIT → all outputs 0 immediately and no `REQ_DONE`. After release, requester 0 is served first.
- `UART_ARB_WDOG_EN`, `WDOG_CYCLES`=16, `TX_FLAG` never asserted → `ERR` pulse 16 cycles after LAUNCH, state IDLE, next requester granted.
